imm_extend_pipe: RTL and testbench

- Next-generation immediate extender for the RISC-V datapath.
- Covers all base immediate formats (I, S, B, J, U), sign-extends to a parametrised XLEN, and registers the result behind a valid/ready handshake with a 2-entry skid buffer.
- Sits between decode and execute in the pipelined core.
- Existing immsrc codes 00 (I), 01 (S) and 10 (B) keep their meaning and bit layout.

---
 rtl/imm_extend_pipe_if.sv | 31 +++
 rtl/imm_extend_pipe.sv | 117 +++++++++++
 tb/tb_imm_extend_pipe.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/imm_extend_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : imm_extend_pipe_if
// Brief    : Decode-to-execute immediate handshake bundle (input side and result side).
// Revision : 1.0
// ============================================================================
interface imm_extend_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [24:0]     instr;
  logic [2:0]      immsrc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] immext;
  logic            illegal;

  // Producer/consumer side (decode + execute)
  modport master (
    output in_valid, instr, immsrc, out_ready,
    input  in_ready, out_valid, immext, illegal
  );

  // Extender block side
  modport slave (
    input  in_valid, instr, immsrc, out_ready,
    output in_ready, out_valid, immext, illegal
  );
endinterface
`default_nettype wire

// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_extend_pipe
// Brief    : RISC-V immediate extender (I/S/B/J/U) behind a valid/ready
//            handshake with a 2-entry (output + skid) buffer.
//            Define IMM_ZIMM_EN to enable the CSR Z-format on immsrc 101.
// Revision : 1.0
// ============================================================================
module imm_extend_pipe #(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             reset,
  imm_extend_pipe_if.slave bus
);

  localparam logic [2:0] c_src_i = 3'b000;
  localparam logic [2:0] c_src_s = 3'b001;
  localparam logic [2:0] c_src_b = 3'b010;
  localparam logic [2:0] c_src_j = 3'b011;
  localparam logic [2:0] c_src_u = 3'b100;
`ifdef IMM_ZIMM_EN
  localparam logic [2:0] c_src_z = 3'b101;
`endif

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_extend_pipe: XLEN must be 32 or 64");
    end
  endgenerate

  // Keep native RISC-V bit numbering for the instruction fields
  logic [31:7]     w_i;
  logic [31:0]     w_imm32;
  logic            w_ill;
  logic [XLEN-1:0] w_dec;

  assign w_i = bus.instr;

  always_comb begin
    w_imm32 = '0;
    w_ill   = 1'b0;
    case (bus.immsrc)
      c_src_i: w_imm32 = {{20{w_i[31]}}, w_i[31:20]};
      c_src_s: w_imm32 = {{20{w_i[31]}}, w_i[31:25], w_i[11:7]};
      c_src_b: w_imm32 = {{20{w_i[31]}}, w_i[7], w_i[30:25], w_i[11:8], 1'b0};
      c_src_j: w_imm32 = {{12{w_i[31]}}, w_i[19:12], w_i[20], w_i[30:21], 1'b0};
      c_src_u: w_imm32 = {w_i[31:12], 12'b0};
`ifdef IMM_ZIMM_EN
      c_src_z: w_imm32 = {27'b0, w_i[19:15]};
`endif
      default: w_ill = 1'b1;
    endcase
  end

  // Bit 31 of every 32-bit form is already the correct extension bit
  generate
    if (XLEN == 32) begin : g_xlen32
      assign w_dec = w_imm32;
    end else begin : g_xlenwide
      assign w_dec = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end
  endgenerate

  logic            r_o_valid;
  logic [XLEN-1:0] r_o_imm;
  logic            r_o_ill;
  logic            r_k_valid;
  logic [XLEN-1:0] r_k_imm;
  logic            r_k_ill;
  logic            r_in_ready;

  logic w_accept;
  logic w_pop;

  assign w_accept = bus.in_valid & r_in_ready;
  assign w_pop    = r_o_valid & bus.out_ready;

  // r_in_ready mirrors ~r_k_valid so in_ready comes straight off a flop
  always_ff @(posedge clk) begin
    if (reset) begin
      r_o_valid  <= 1'b0;
      r_o_imm    <= '0;
      r_o_ill    <= 1'b0;
      r_k_valid  <= 1'b0;
      r_k_imm    <= '0;
      r_k_ill    <= 1'b0;
      r_in_ready <= 1'b1;
    end else if (w_pop && r_k_valid) begin
      r_o_imm    <= r_k_imm;
      r_o_ill    <= r_k_ill;
      r_k_valid  <= 1'b0;
      r_in_ready <= 1'b1;
    end else if (w_pop && w_accept) begin
      r_o_imm <= w_dec;
      r_o_ill <= w_ill;
    end else if (w_pop) begin
      r_o_valid <= 1'b0;
    end else if (!r_o_valid && w_accept) begin
      r_o_valid <= 1'b1;
      r_o_imm   <= w_dec;
      r_o_ill   <= w_ill;
    end else if (r_o_valid && w_accept) begin
      r_k_valid  <= 1'b1;
      r_k_imm    <= w_dec;
      r_k_ill    <= w_ill;
      r_in_ready <= 1'b0;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_o_valid;
  assign bus.immext    = r_o_imm;
  assign bus.illegal   = r_o_ill;

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// Directed self-checking bench for imm_extend_pipe (XLEN=32 and XLEN=64 instances).
module tb_imm_extend_pipe;

  logic clk;
  logic reset;
  int   n_total;
  int   n_bad;

  imm_extend_pipe_if #(.XLEN(32)) bus32 ();
  imm_extend_pipe_if #(.XLEN(64)) bus64 ();

  imm_extend_pipe #(.XLEN(32)) u_dut32 (.clk(clk), .reset(reset), .bus(bus32.slave));
  imm_extend_pipe #(.XLEN(64)) u_dut64 (.clk(clk), .reset(reset), .bus(bus64.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] src, input logic [31:0] word);
    bus32.in_valid = v;
    bus32.immsrc   = src;
    bus32.instr    = word[31:7];
  endtask

  // One transfer with out_ready high; result must show the following cycle
  task automatic single(input string tag, input logic [2:0] src, input logic [31:0] word,
                        input logic [63:0] eimm, input logic eill);
    drive(1'b1, src, word);
    bus32.out_ready = 1'b1;
    @(negedge clk);
    drive(1'b0, 3'b000, 32'h0);
    check({tag, "_valid"}, {63'b0, bus32.out_valid}, 64'd1);
    check({tag, "_imm"}, {32'b0, bus32.immext}, eimm);
    check({tag, "_ill"}, {63'b0, bus32.illegal}, {63'b0, eill});
  endtask

  logic [2:0]  bb_src [3] = '{3'b001, 3'b010, 3'b011};
  logic [31:0] bb_word[3] = '{32'hFE512E23, 32'h00000463, 32'h001000EF};
  logic [31:0] bb_exp [3] = '{32'hFFFFFFFC, 32'h00000008, 32'h00000800};

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset   = 1'b1;
    drive(1'b0, 3'b000, 32'h0);
    bus32.out_ready = 1'b0;
    bus64.in_valid  = 1'b0;
    bus64.immsrc    = 3'b000;
    bus64.instr     = '0;
    bus64.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {63'b0, bus32.out_valid}, 64'd0);
    check("rst_in_ready", {63'b0, bus32.in_ready}, 64'd1);
    check("rst_immext", {32'b0, bus32.immext}, 64'd0);
    check("rst_illegal", {63'b0, bus32.illegal}, 64'd0);
    check("rst64_immext", bus64.immext, 64'd0);
    reset = 1'b0;

    single("i_fmt", 3'b000, 32'hFFF00093, 64'hFFFFFFFF, 1'b0);
    @(negedge clk);
    check("i_fmt_drain", {63'b0, bus32.out_valid}, 64'd0);

    // Back-to-back, one result per cycle in order
    bus32.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, bb_src[i], bb_word[i]);
      @(negedge clk);
      check($sformatf("bb%0d_valid", i), {63'b0, bus32.out_valid}, 64'd1);
      check($sformatf("bb%0d_imm", i), {32'b0, bus32.immext}, {32'b0, bb_exp[i]});
      check($sformatf("bb%0d_rdy", i), {63'b0, bus32.in_ready}, 64'd1);
    end
    drive(1'b0, 3'b000, 32'h0);
    @(negedge clk);
    check("bb_drain", {63'b0, bus32.out_valid}, 64'd0);

    // U-format on both widths
    drive(1'b1, 3'b100, 32'h800000B7);
    bus64.in_valid  = 1'b1;
    bus64.immsrc    = 3'b100;
    bus64.instr     = 25'h1000001;
    bus64.out_ready = 1'b1;
    @(negedge clk);
    drive(1'b0, 3'b000, 32'h0);
    bus64.in_valid = 1'b0;
    check("u32_imm", {32'b0, bus32.immext}, 64'h0000000080000000);
    check("u64_valid", {63'b0, bus64.out_valid}, 64'd1);
    check("u64_imm", bus64.immext, 64'hFFFFFFFF80000000);
    check("u64_ill", {63'b0, bus64.illegal}, 64'd0);

    single("ill111", 3'b111, 32'hFFFFFFFF, 64'h0, 1'b1);
    single("ill110", 3'b110, 32'h12345678, 64'h0, 1'b1);
`ifdef IMM_ZIMM_EN
    single("z101", 3'b101, 32'h000F8073, 64'h1F, 1'b0);
`else
    single("z101", 3'b101, 32'h000F8073, 64'h0, 1'b1);
`endif
    @(negedge clk);

    // Stall: fill O and K, third input held off, then drain in order
    bus32.out_ready = 1'b0;
    drive(1'b1, 3'b000, 32'h00100093);
    @(negedge clk);
    check("st1_valid", {63'b0, bus32.out_valid}, 64'd1);
    check("st1_imm", {32'b0, bus32.immext}, 64'd1);
    check("st1_rdy", {63'b0, bus32.in_ready}, 64'd1);
    drive(1'b1, 3'b000, 32'h00200093);
    @(negedge clk);
    check("st2_rdy", {63'b0, bus32.in_ready}, 64'd0);
    check("st2_imm", {32'b0, bus32.immext}, 64'd1);
    drive(1'b1, 3'b000, 32'h00300093);
    @(negedge clk);
    check("st3_rdy", {63'b0, bus32.in_ready}, 64'd0);
    check("st3_hold", {32'b0, bus32.immext}, 64'd1);
    bus32.out_ready = 1'b1;
    @(negedge clk);
    check("st_out2", {32'b0, bus32.immext}, 64'd2);
    check("st_out2_rdy", {63'b0, bus32.in_ready}, 64'd1);
    @(negedge clk);
    drive(1'b0, 3'b000, 32'h0);
    check("st_out3_valid", {63'b0, bus32.out_valid}, 64'd1);
    check("st_out3", {32'b0, bus32.immext}, 64'd3);
    @(negedge clk);
    check("st_drain", {63'b0, bus32.out_valid}, 64'd0);

    // Reset with both entries full, input offered in the reset cycle
    bus32.out_ready = 1'b0;
    drive(1'b1, 3'b000, 32'h00500093);
    @(negedge clk);
    drive(1'b1, 3'b000, 32'h00600093);
    @(negedge clk);
    check("rf_full_rdy", {63'b0, bus32.in_ready}, 64'd0);
    reset = 1'b1;
    drive(1'b1, 3'b000, 32'h00700093);
    @(negedge clk);
    reset = 1'b0;
    check("rf_out_valid", {63'b0, bus32.out_valid}, 64'd0);
    check("rf_in_ready", {63'b0, bus32.in_ready}, 64'd1);
    check("rf_immext", {32'b0, bus32.immext}, 64'd0);
    bus32.out_ready = 1'b1;
    @(negedge clk);
    drive(1'b0, 3'b000, 32'h0);
    check("rf_next_valid", {63'b0, bus32.out_valid}, 64'd1);
    check("rf_next_imm", {32'b0, bus32.immext}, 64'd7);
    @(negedge clk);
    check("rf_no_dup", {63'b0, bus32.out_valid}, 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
